// File: rtl/matrix_mac_sequencer_if.sv
// Control, matrix-store and result bus of the matrix multiply-accumulate sequencer.
// slave = sequencer side, master = requester / memory side.
interface matrix_mac_sequencer_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic          start;
    logic [AW-1:0] m_dim;
    logic [AW-1:0] n_dim;
    logic [AW-1:0] p_dim;
    logic          a_read;
    logic [AW-1:0] a_m_addr;
    logic [AW-1:0] a_n_addr;
    logic [DW-1:0] a_data;
    logic          b_read;
    logic [AW-1:0] b_m_addr;
    logic [AW-1:0] b_n_addr;
    logic [DW-1:0] b_data;
    logic          c_write;
    logic [AW-1:0] c_m_addr;
    logic [AW-1:0] c_n_addr;
    logic [DW-1:0] c_data;
    logic          busy;
    logic          done;
    logic          err;

    modport slave (
        input  start, m_dim, n_dim, p_dim, a_data, b_data,
        output a_read, a_m_addr, a_n_addr, b_read, b_m_addr, b_n_addr,
        output c_write, c_m_addr, c_n_addr, c_data, busy, done, err
    );

    modport master (
        output start, m_dim, n_dim, p_dim, a_data, b_data,
        input  a_read, a_m_addr, a_n_addr, b_read, b_m_addr, b_n_addr,
        input  c_write, c_m_addr, c_n_addr, c_data, busy, done, err
    );
endinterface

// File: rtl/matrix_mac_sequencer.sv
// Computes C = A x B element by element in row-major order, one dot product per (n+2) cycles.
// Latency: DONE entered 1+m*p*(n+2) edges after start; start is ignored while busy (no backpressure).
module matrix_mac_sequencer #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic                    clk_tb,
    input  logic                    reset_tb,
    matrix_mac_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [AW-1:0] ONE = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] m_q, m_d, n_q, n_d, p_q, p_d;
    logic [AW-1:0] r_q, r_d, c_q, c_d, k_q, k_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] prod;
    logic          dim_zero;
    logic          last_k;
    logic          last_c;
    logic          last_elem;

    // Product of the operands returned for the address issued last cycle, truncated to DW.
    assign prod      = bus.a_data * bus.b_data;
    assign dim_zero  = (m_q == '0) || (n_q == '0) || (p_q == '0);
    assign last_k    = (k_q == n_q - ONE);
    assign last_c    = (c_q == p_q - ONE);
    assign last_elem = last_c && (r_q == m_q - ONE);

    always_ff @(posedge clk_tb or negedge reset_tb) begin
        if (!reset_tb) begin
            state_q <= IDLE;
            m_q     <= '0;
            n_q     <= '0;
            p_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            p_q     <= p_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CHECK;
            CHECK:   state_d = dim_zero ? DONE : FETCH;
            FETCH:   if (last_k) state_d = DRAIN;
            DRAIN:   state_d = WRITE;
            WRITE:   state_d = last_elem ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_d   = m_q;
        n_d   = n_q;
        p_d   = p_q;
        r_d   = r_q;
        c_d   = c_q;
        k_d   = k_q;
        acc_d = acc_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d = bus.m_dim;
                    n_d = bus.n_dim;
                    p_d = bus.p_dim;
                end
            end
            CHECK: begin
                r_d   = '0;
                c_d   = '0;
                k_d   = '0;
                acc_d = '0;
            end
            FETCH: begin
                // Cycle k=0 has no returning data yet; the last product lands in DRAIN.
                if (k_q != '0) acc_d = acc_q + prod;
                k_d = last_k ? '0 : k_q + ONE;
            end
            DRAIN: acc_d = acc_q + prod;
            WRITE: begin
                acc_d = '0;
                if (last_c) begin
                    c_d = '0;
                    r_d = r_q + ONE;
                end else begin
                    c_d = c_q + ONE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.a_read   = 1'b0;
        bus.a_m_addr = '0;
        bus.a_n_addr = '0;
        bus.b_read   = 1'b0;
        bus.b_m_addr = '0;
        bus.b_n_addr = '0;
        bus.c_write  = 1'b0;
        bus.c_m_addr = '0;
        bus.c_n_addr = '0;
        bus.c_data   = '0;
        bus.busy     = (state_q != IDLE);
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        case (state_q)
            CHECK: bus.err = dim_zero;
            FETCH: begin
                bus.a_read   = 1'b1;
                bus.a_m_addr = r_q;
                bus.a_n_addr = k_q;
                bus.b_read   = 1'b1;
                bus.b_m_addr = k_q;
                bus.b_n_addr = c_q;
            end
            WRITE: begin
                bus.c_write  = 1'b1;
                bus.c_m_addr = r_q;
                bus.c_n_addr = c_q;
                bus.c_data   = acc_q;
            end
            DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule
